// File: rtl/alu_pkg.sv
// Shared ALU definitions: operation codes, datapath widths and the control
// bundle carried through the ID/EX register.
package alu_pkg;

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 5;

  localparam logic [2:0] ALU_SLL = 3'd0;
  localparam logic [2:0] ALU_OR  = 3'd1;
  localparam logic [2:0] ALU_SRL = 3'd2;
  localparam logic [2:0] ALU_AND = 3'd3;
  localparam logic [2:0] ALU_ADD = 3'd4;
  localparam logic [2:0] ALU_NOR = 3'd5;
  localparam logic [2:0] ALU_SUB = 3'd6;

  typedef struct packed {
    logic          reg_write;
    logic          mem_read;
    logic          mem_write;
    logic [RW-1:0] rd;
  } id_ex_ctrl_t;

endpackage

// File: rtl/fwd_sel.sv
// Three-way operand forwarding mux: EX result, then MEM result, then register
// file. Register 0 always reads as zero and is never forwarded.
module fwd_sel #(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic [RW-1:0] src,
  input  logic [DW-1:0] rf_data,
  input  logic          ex_fwd,
  input  logic [RW-1:0] ex_rd,
  input  logic [DW-1:0] ex_data,
  input  logic          mem_fwd,
  input  logic [RW-1:0] mem_rd,
  input  logic [DW-1:0] mem_data,
  output logic [DW-1:0] data
);

  // Priority select, youngest producer first
  always_comb begin
    data = rf_data;
    if (src == '0) begin
      data = '0;
    end else if (ex_fwd && (ex_rd == src)) begin
      data = ex_data;
    end else if (mem_fwd && (mem_rd == src)) begin
      data = mem_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the combinational ALU. Resolves operand
// forwarding and load-use hazards, valid/ready on both sides, sync flush.
// Optional macro ID_EX_PERF_CNT_EN adds stall_cnt / flush_cnt counters.
module id_ex_stage
  import alu_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned RW = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_aluop,
  input  logic [RW-1:0] in_rs_addr,
  input  logic [RW-1:0] in_rt_addr,
  input  logic          in_rs_used,
  input  logic          in_rt_used,
  input  logic [DW-1:0] in_rs_data,
  input  logic [DW-1:0] in_rt_data,
  input  logic [DW-1:0] in_imm,
  input  logic          in_use_imm,
  input  logic          in_is_shift,
  input  logic [4:0]    in_shamt,
  input  logic [RW-1:0] in_rd_addr,
  input  logic          in_reg_write,
  input  logic          in_mem_read,
  input  logic          in_mem_write,
  input  logic          flush,
  input  logic [DW-1:0] ex_result,
  input  logic          mem_reg_write,
  input  logic [RW-1:0] mem_rd,
  input  logic [DW-1:0] mem_result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [2:0]    alu_op,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [DW-1:0] out_store_data,
  output logic [RW-1:0] out_rd_addr,
  output logic          out_reg_write,
  output logic          out_mem_read,
  output logic          out_mem_write
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]   stall_cnt,
  output logic [31:0]   flush_cnt
`endif
);

  logic          valid_q;
  id_ex_ctrl_t   ctrl_q;
  logic [2:0]    op_q;
  logic [DW-1:0] a_q, b_q, sd_q;

  logic          hz, capture, ex_fwd;
  logic [DW-1:0] fwd_rs, fwd_rt;
  logic [DW-1:0] a_next, b_next;

  // Held instruction forwards its result only if it is an ALU op, not a load
  assign ex_fwd = valid_q & ctrl_q.reg_write & ~ctrl_q.mem_read;

  // Load-use: the load's data is not available until it reaches MEM
  assign hz = valid_q & ctrl_q.mem_read & (ctrl_q.rd != '0) &
              ((in_rs_used & (in_rs_addr == ctrl_q.rd)) |
               (in_rt_used & (in_rt_addr == ctrl_q.rd)));

  assign in_ready = (~valid_q | out_ready) & ~hz & ~flush;
  assign capture  = in_valid & in_ready;

  fwd_sel #(.DW(DW), .RW(RW)) u_fwd_rs (
    .src      (in_rs_addr),
    .rf_data  (in_rs_data),
    .ex_fwd   (ex_fwd),
    .ex_rd    (ctrl_q.rd),
    .ex_data  (ex_result),
    .mem_fwd  (mem_reg_write),
    .mem_rd   (mem_rd),
    .mem_data (mem_result),
    .data     (fwd_rs)
  );

  fwd_sel #(.DW(DW), .RW(RW)) u_fwd_rt (
    .src      (in_rt_addr),
    .rf_data  (in_rt_data),
    .ex_fwd   (ex_fwd),
    .ex_rd    (ctrl_q.rd),
    .ex_data  (ex_result),
    .mem_fwd  (mem_reg_write),
    .mem_rd   (mem_rd),
    .mem_data (mem_result),
    .data     (fwd_rt)
  );

  assign a_next = in_is_shift ? {{(DW-5){1'b0}}, in_shamt} : fwd_rs;
  assign b_next = in_use_imm ? in_imm : fwd_rt;

  // Pipeline register: flush beats capture beats drain; otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      op_q    <= ALU_SLL;
      a_q     <= '0;
      b_q     <= '0;
      sd_q    <= '0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (capture) begin
      valid_q          <= 1'b1;
      ctrl_q.reg_write <= in_reg_write;
      ctrl_q.mem_read  <= in_mem_read;
      ctrl_q.mem_write <= in_mem_write;
      ctrl_q.rd        <= in_rd_addr;
      op_q             <= in_aluop;
      a_q              <= a_next;
      b_q              <= b_next;
      sd_q             <= fwd_rt;
    end else if (valid_q && out_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign out_valid      = valid_q;
  assign alu_op         = op_q;
  assign alu_a          = a_q;
  assign alu_b          = b_q;
  assign out_store_data = sd_q;
  assign out_rd_addr    = ctrl_q.rd;
  assign out_reg_write  = ctrl_q.reg_write;
  assign out_mem_read   = ctrl_q.mem_read;
  assign out_mem_write  = ctrl_q.mem_write;

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] stall_q, flush_q;

  // Event counters, free-running with natural wrap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (in_valid && hz)               stall_q <= stall_q + 32'd1;
      if (flush && (valid_q || in_valid)) flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`endif

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Pipeline register stage directly upstream of the ALU. Captures decoded instructions from ID and resolves operand forwarding and load-use hazards.
- Presents registered ALUOp/ALU_A/ALU_B to the ALU, which is combinational.
- Uses a valid/ready handshake on both sides. Supports synchronous flush for branch mispredict.

Parameters:
- DW, 32, datapath width.
- RW, 5, register address width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  ID presents an instruction
- in_ready  out  1  stage accepts the instruction this cycle
- in_aluop  in  3  ALU operation code, 0..6 (see package)
- in_rs_addr / in_rt_addr  in  RW  source register numbers
- in_rs_used / in_rt_used  in  1  source is actually read
- in_rs_data / in_rt_data  in  DW  register-file read data
- in_imm  in  DW  sign/zero-extended immediate
- in_use_imm  in  1  ALU_B = imm instead of rt
- in_is_shift  in  1  ALU_A = {27'b0, in_shamt}
- in_shamt  in  5  shift amount
- in_rd_addr  in  RW  destination register
- in_reg_write / in_mem_read / in_mem_write  in  1  control bits
- flush  in  1  kill the held instruction and the incoming one
- ex_result  in  DW  ALU result of the instruction currently held
- mem_reg_write  in  1  MEM stage writes a register
- mem_rd  in  RW  MEM destination register
- mem_result  in  DW  MEM write-back value (load data for loads)
- out_valid  out  1  held instruction valid
- out_ready  in  1  downstream (EX/MEM) accepts
- alu_op  out  3  to ALU ALUOp
- alu_a / alu_b  out  DW  to ALU_A / ALU_B
- out_store_data  out  DW  forwarded rt, for stores
- out_rd_addr  out  RW  held destination register
- out_reg_write / out_mem_read / out_mem_write  out  1  held control bits

Behaviour:
- Reset (async, rst_n=0): out_valid=0; alu_op=0; alu_a, alu_b, out_store_data=0; out_rd_addr=0; all out control bits=0.
- Hazard: hz = out_valid & out_mem_read & (out_rd_addr!=0) & ((in_rs_used & in_rs_addr==out_rd_addr) | (in_rt_used & in_rt_addr==out_rd_addr)).
- in_ready = (~out_valid | out_ready) & ~hz & ~flush. Combinational; no dependency on in_valid.
- Capture when in_valid & in_ready. All outputs update on the next edge (latency 1).
- Forwarding per source, priority high to low:
  - EX (held instr: out_valid & out_reg_write & ~out_mem_read & rd match) -> ex_result.
  - MEM (mem_reg_write & mem_rd match) -> mem_result.
  - Otherwise register-file data.
  - Register 0 is never forwarded and always reads 0.
- Operand mapping:
  - alu_a = in_is_shift ? {27'b0, in_shamt} : fwd_rs.
  - alu_b = in_use_imm ? in_imm : fwd_rt.
  - out_store_data = fwd_rt.
  - Shifts therefore shift B by A[4:0].
- State transitions, priority top to bottom:
  - flush -> out_valid<=0.
  - Capture -> load new instruction, out_valid<=1.
  - out_valid & out_ready & no capture -> out_valid<=0 (bubble). This is the load-use case: the dependent instruction is captured one cycle later with load data via MEM forwarding.
  - Otherwise hold every register unchanged.
- Simultaneous drain and capture at full throughput: one instruction per cycle.
- flush while in_valid=1: the incoming instruction is dropped; ID re-presents or discards it.
- in_aluop=7 is captured as-is; the ALU outputs 0 for it.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- Defined:
  - Adds outputs stall_cnt[31:0] (cycles with in_valid & hz) and flush_cnt[31:0] (cycles with flush & (out_valid | in_valid)).
  - Both reset to 0 and wrap at 2^32.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Package alu_pkg:
  - ALUOp constants ALU_SLL=0, ALU_OR=1, ALU_SRL=2, ALU_AND=3, ALU_ADD=4, ALU_NOR=5, ALU_SUB=6.
  - Localparams DW=32, RW=5.
  - Struct id_ex_ctrl_t (reg_write, mem_read, mem_write, rd).
- Sub-module fwd_sel: combinational three-way forwarding mux with zero-register guard, instantiated for rs and rt.

Test Plan:
- Reset mid-stream: rst_n low with out_valid=1 -> out_valid=0 and all outputs 0 immediately, before any clock edge.
- Back-to-back dependency: add r3=r1+r2 then sub r4=r3-r1, with ex_result=0x10 -> second instruction captures alu_a=0x10, alu_op=6, with no bubble.
- Load-use: lw r5 held, next instruction uses r5 -> in_ready=0 for one cycle and out_valid=0 one cycle. Next capture takes mem_result=0xDEADBEEF as the operand.
- Forward priority: ex and mem both target r7 (0x1 vs 0x2) -> 0x1 chosen. Source r0 with mem_rd=0, mem_reg_write=1 -> operand stays 0.
- Shift mapping: sll with shamt=4, rt=0x1 -> alu_a=4, alu_b=1, alu_op=0.
- Backpressure and flush:
  - out_ready=0 for 3 cycles -> all outputs stable, in_ready=0.
  - flush with in_valid=1 -> out_valid=0 next cycle and the incoming instruction is not captured.
  - With ID_EX_PERF_CNT_EN, flush_cnt increments by 1.
